// File: rtl/gf2_pkg.sv
// Shared types for the GF(2) reduction engine and the downstream solver:
// FSM state encoding, count-width helper and generic row/column index types.
package gf2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SWAP,
        ELIM,
        NEXT_COL,
        DONE
    } state_t;

    // Width needed to hold a count in 0..n (at least 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

    // Index types wide enough for any practical matrix size (up to 255).
    localparam int IDX_W = 8;
    typedef logic [IDX_W-1:0] row_idx_t;
    typedef logic [IDX_W-1:0] col_idx_t;

endpackage

// File: rtl/gf2_pivot_scan.sv
// Pivot search over one column slice from row prow to rows-1 (lowest index wins).
// GF2_RREF_ENGINE_FAST_SCAN_EN selects a one-cycle priority encoder, otherwise one row per cycle.
module gf2_pivot_scan #(
    parameter int MAX_ROWS = 16,
    parameter int ROW_W    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                active,
    input  logic [MAX_ROWS-1:0] col_bits,
    input  logic [ROW_W-1:0]    prow,
    input  logic [ROW_W-1:0]    rows,
    output logic                hit,
    output logic                miss,
    output logic [ROW_W-1:0]    p
);

`ifdef GF2_RREF_ENGINE_FAST_SCAN_EN
    logic [MAX_ROWS-1:0] win;
    logic                unused_fast;

    assign unused_fast = &{1'b0, clk, rst_n, start};

    always_comb begin
        win = col_bits & ({MAX_ROWS{1'b1}} << prow) & ~({MAX_ROWS{1'b1}} << rows);
        p   = '0;
        for (int i = MAX_ROWS - 1; i >= 0; i--) begin
            if (win[i]) p = ROW_W'(i);
        end
        hit  = active && (|win);
        miss = active && !(|win);
    end
`else
    logic [ROW_W-1:0]    cur;
    logic [ROW_W-1:0]    eff;
    logic [MAX_ROWS-1:0] sh;

    // The row under test is resolved combinationally so a hit costs no extra cycle.
    always_comb begin
        eff  = start ? prow : cur;
        sh   = col_bits >> eff;
        hit  = active && sh[0];
        miss = active && !sh[0] && (eff + ROW_W'(1) == rows);
        p    = eff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cur <= '0;
        else if (active) cur <= eff + ROW_W'(1);
    end
`endif

endmodule

// File: rtl/gf2_rref_engine.sv
// GF(2) Gauss-Jordan engine: reduces a runtime-sized bit matrix to RREF, reporting rank,
// pivot columns and (augmented mode) consistency. GF2_RREF_ENGINE_FAST_SCAN_EN selects 1-cycle scan.
module gf2_rref_engine
    import gf2_pkg::*;
#(
    parameter int MAX_ROWS   = 16,
    parameter int MAX_COLS   = 16,
    parameter int MAX_ROWS_W = cnt_w(MAX_ROWS),
    parameter int MAX_COLS_W = cnt_w(MAX_COLS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MAX_ROWS_W-1:0]              rows,
    input  logic [MAX_COLS_W-1:0]              cols,
    input  logic                               aug_mode,
    input  logic [MAX_ROWS-1:0][MAX_COLS-1:0]  mat_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MAX_ROWS-1:0][MAX_COLS-1:0]  rref,
    output logic [MAX_ROWS_W-1:0]              rank,
    output logic [MAX_COLS-1:0]                pivot_mask,
    output logic                               consistent
);

    typedef logic [MAX_ROWS-1:0][MAX_COLS-1:0] mat_t;

    // Column 0 lives in the MSB of each row.
    localparam logic [MAX_COLS-1:0] COL0 = MAX_COLS'(1) << (MAX_COLS - 1);

    state_t                state, nxt;
    mat_t                  mat, cap_mat, fin_mat;
    logic [MAX_ROWS_W-1:0] rows_q, prow, piv, rows_sat, scan_p, fin_rank;
    logic [MAX_COLS_W-1:0] cols_q, ncoef, col, cols_sat, ncoef_in, fin_cols;
    logic [MAX_COLS-1:0]   pmask, prow_row, piv_row, col_sh, cap_cmask, rhs_bit, fin_pmask;
    logic [MAX_ROWS-1:0]   col_bits;
    logic                  aug_q, fin_aug, fin_cons, degen, load_out;
    logic                  scan_first, scan_en, scan_hit, scan_miss;

    always_comb begin
        rows_sat  = (rows > MAX_ROWS_W'(MAX_ROWS)) ? MAX_ROWS_W'(MAX_ROWS) : rows;
        cols_sat  = (cols > MAX_COLS_W'(MAX_COLS)) ? MAX_COLS_W'(MAX_COLS) : cols;
        ncoef_in  = (aug_mode && cols_sat != '0) ? cols_sat - MAX_COLS_W'(1) : cols_sat;
        degen     = (rows_sat == '0) || (ncoef_in == '0);
        cap_cmask = ~({MAX_COLS{1'b1}} >> cols_sat);
        cap_mat   = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            if (MAX_ROWS_W'(r) < rows_sat) cap_mat[r] = mat_in[r] & cap_cmask;
        end
    end

    always_comb begin
        col_bits = '0;
        prow_row = '0;
        piv_row  = '0;
        col_sh   = '0;
        for (int r = 0; r < MAX_ROWS; r++) begin
            col_sh      = mat[r] << col;
            col_bits[r] = col_sh[MAX_COLS-1];
            if (MAX_ROWS_W'(r) == prow) prow_row = mat[r];
            if (MAX_ROWS_W'(r) == piv)  piv_row  = mat[r];
        end
    end

    // Result snapshot; the degenerate path goes to DONE straight from IDLE using the capture view.
    always_comb begin
        fin_mat   = (state == IDLE) ? cap_mat  : mat;
        fin_rank  = (state == IDLE) ? '0       : prow;
        fin_pmask = (state == IDLE) ? '0       : pmask;
        fin_aug   = (state == IDLE) ? aug_mode : aug_q;
        fin_cols  = (state == IDLE) ? cols_sat : cols_q;
        rhs_bit   = (fin_cols == '0) ? '0 : COL0 >> (fin_cols - MAX_COLS_W'(1));
        fin_cons  = 1'b1;
        if (fin_aug) begin
            for (int r = 0; r < MAX_ROWS; r++) begin
                if (MAX_ROWS_W'(r) >= fin_rank && (fin_mat[r] & rhs_bit) != '0) fin_cons = 1'b0;
            end
        end
    end

    gf2_pivot_scan #(
        .MAX_ROWS (MAX_ROWS),
        .ROW_W    (MAX_ROWS_W)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (scan_first),
        .active   (scan_en),
        .col_bits (col_bits),
        .prow     (prow),
        .rows     (rows_q),
        .hit      (scan_hit),
        .miss     (scan_miss),
        .p        (scan_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            scan_first <= 1'b0;
        end else begin
            state      <= nxt;
            scan_first <= (nxt == SCAN) && (state != SCAN);
        end
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        scan_en   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = degen ? DONE : SCAN;
            end
            SCAN: begin
                scan_en = 1'b1;
                if (scan_hit)       nxt = (scan_p == prow) ? ELIM : SWAP;
                else if (scan_miss) nxt = NEXT_COL;
            end
            SWAP:     nxt = ELIM;
            ELIM:     nxt = NEXT_COL;
            NEXT_COL: nxt = (col + MAX_COLS_W'(1) == ncoef || prow == rows_q) ? DONE : SCAN;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default:  nxt = IDLE;
        endcase
        load_out = (nxt == DONE) && (state != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q     <= '0;
            cols_q     <= '0;
            ncoef      <= '0;
            aug_q      <= 1'b0;
            mat        <= '0;
            col        <= '0;
            prow       <= '0;
            piv        <= '0;
            pmask      <= '0;
            rref       <= '0;
            rank       <= '0;
            pivot_mask <= '0;
            consistent <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    rows_q <= rows_sat;
                    cols_q <= cols_sat;
                    ncoef  <= ncoef_in;
                    aug_q  <= aug_mode;
                    mat    <= cap_mat;
                    col    <= '0;
                    prow   <= '0;
                    pmask  <= '0;
                end
                SCAN: if (scan_hit) piv <= scan_p;
                SWAP: begin
                    for (int r = 0; r < MAX_ROWS; r++) begin
                        if (MAX_ROWS_W'(r) == piv)       mat[r] <= prow_row;
                        else if (MAX_ROWS_W'(r) == prow) mat[r] <= piv_row;
                    end
                end
                ELIM: begin
                    for (int r = 0; r < MAX_ROWS; r++) begin
                        if (MAX_ROWS_W'(r) != prow && col_bits[r]) mat[r] <= mat[r] ^ prow_row;
                    end
                    pmask <= pmask | (COL0 >> col);
                    prow  <= prow + MAX_ROWS_W'(1);
                end
                NEXT_COL: col <= col + MAX_COLS_W'(1);
                default: ;
            endcase
            if (load_out) begin
                rref       <= fin_mat;
                rank       <= fin_rank;
                pivot_mask <= fin_pmask;
                consistent <= fin_cons;
            end
        end
    end

endmodule

// File: tb/tb_gf2_rref_engine.sv
// Self-checking bench for gf2_rref_engine: directed cases plus random matrices
// compared against a plain array-based Gauss-Jordan reference.
module tb_gf2_rref_engine;

    localparam int MR = 16;
    localparam int MC = 16;
    localparam int RW = $clog2(MR + 1);
    localparam int CW = $clog2(MC + 1);

    typedef logic [MR-1:0][MC-1:0] mat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, aug_mode, out_valid, out_ready, consistent;
    logic [RW-1:0] rows, rank;
    logic [CW-1:0] cols;
    mat_t          mat_in, rref;
    logic [MC-1:0] pivot_mask;

    int n_pass = 0;
    int n_tot  = 0;

    mat_t          exp_rref;
    int            exp_rank;
    logic [MC-1:0] exp_pm;
    bit            exp_cons;

    gf2_rref_engine #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rows       (rows),
        .cols       (cols),
        .aug_mode   (aug_mode),
        .mat_in     (mat_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rref       (rref),
        .rank       (rank),
        .pivot_mask (pivot_mask),
        .consistent (consistent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Row whose leftmost n columns are the n-bit value v written MSB-first.
    function automatic logic [MC-1:0] mk(input logic [MC-1:0] v, input int n);
        return v << (MC - n);
    endfunction

    task automatic ref_model(input mat_t m, input int nr_in, input int nc_in, input bit aug);
        bit a [MR][MC];
        bit t;
        int nr, nc, ncf, rk, p;
        nr = (nr_in > MR) ? MR : nr_in;
        nc = (nc_in > MC) ? MC : nc_in;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++)
                a[r][c] = (r < nr && c < nc) ? m[r][MC-1-c] : 1'b0;
        ncf    = (aug && nc > 0) ? nc - 1 : nc;
        rk     = 0;
        exp_pm = '0;
        for (int c = 0; c < ncf; c++) begin
            if (rk < nr) begin
                p = -1;
                for (int r = rk; r < nr; r++) if (p < 0 && a[r][c]) p = r;
                if (p >= 0) begin
                    for (int cc = 0; cc < MC; cc++) begin
                        t = a[p][cc]; a[p][cc] = a[rk][cc]; a[rk][cc] = t;
                    end
                    for (int r = 0; r < MR; r++)
                        if (r != rk && a[r][c])
                            for (int cc = 0; cc < MC; cc++) a[r][cc] ^= a[rk][cc];
                    exp_pm[MC-1-c] = 1'b1;
                    rk++;
                end
            end
        end
        exp_cons = 1'b1;
        if (aug && nc > 0)
            for (int r = rk; r < nr; r++) if (a[r][nc-1]) exp_cons = 1'b0;
        exp_rank = rk;
        for (int r = 0; r < MR; r++)
            for (int c = 0; c < MC; c++) exp_rref[r][MC-1-c] = a[r][c];
    endtask

    task automatic send(input mat_t m, input int nr, input int nc, input bit aug);
        int t = 0;
        while (!in_ready && t < 500) begin @(negedge clk); t++; end
        n_tot++;
        if (in_ready !== 1'b1) $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        else n_pass++;
        mat_in   = m;
        rows     = RW'(nr);
        cols     = CW'(nc);
        aug_mode = aug;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // cyc = 1 in the first cycle after the capture edge.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 3000) begin @(negedge clk); cyc++; end
        n_tot++;
        if (out_valid !== 1'b1) $display("FAIL wait_done: out_valid=%b after %0d cycles", out_valid, cyc);
        else n_pass++;
    endtask

    task automatic check_result(input string name, input mat_t m, input int nr, input int nc, input bit aug);
        ref_model(m, nr, nc, aug);
        n_tot++;
        if (rref !== exp_rref) $display("FAIL %s rref: got %h required %h", name, rref, exp_rref);
        else n_pass++;
        n_tot++;
        if (rank !== RW'(exp_rank)) $display("FAIL %s rank: got %0d required %0d", name, rank, exp_rank);
        else n_pass++;
        n_tot++;
        if (pivot_mask !== exp_pm) $display("FAIL %s pivot_mask: got %h required %h", name, pivot_mask, exp_pm);
        else n_pass++;
        n_tot++;
        if (consistent !== exp_cons) $display("FAIL %s consistent: got %b required %b", name, consistent, exp_cons);
        else n_pass++;
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tot++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL %s accept: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic run(input string name, input mat_t m, input int nr, input int nc, input bit aug);
        int cyc;
        send(m, nr, nc, aug);
        wait_done(cyc);
        check_result(name, m, nr, nc, aug);
    endtask

    task automatic test_reset();
        n_tot++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        else n_pass++;
        n_tot++;
        if (rref !== '0 || rank !== '0 || pivot_mask !== '0 || consistent !== 1'b1)
            $display("FAIL reset_out: rref=%h rank=%0d pm=%h cons=%b required 0/0/0/1", rref, rank, pivot_mask, consistent);
        else n_pass++;
    endtask

    task automatic test_latency_1x1();
        mat_t m = '0;
        int   cyc;
        m[0] = mk(1, 1);
        send(m, 1, 1, 1'b0);
        wait_done(cyc);
        n_tot++;
        if (cyc != 4) $display("FAIL latency_1x1: out_valid in cycle %0d required 4", cyc);
        else n_pass++;
        check_result("one_by_one", m, 1, 1, 1'b0);
        release_result("one_by_one");
    endtask

    task automatic test_directed();
        mat_t m;
        mat_t e;
        m = '0; m[0] = mk(3'b100, 3); m[1] = mk(3'b010, 3); m[2] = mk(3'b001, 3);
        run("identity", m, 3, 3, 1'b0);
        n_tot++;
        if (rref !== m || rank !== RW'(3) || pivot_mask !== mk(3'b111, 3))
            $display("FAIL identity_const: rref=%h rank=%0d pm=%h", rref, rank, pivot_mask);
        else n_pass++;
        release_result("identity");

        m = '0; m[0] = mk(3'b011, 3); m[1] = mk(3'b101, 3); m[2] = mk(3'b110, 3);
        e = '0; e[0] = mk(3'b101, 3); e[1] = mk(3'b011, 3);
        run("swap", m, 3, 3, 1'b0);
        n_tot++;
        if (rref !== e || rank !== RW'(2) || pivot_mask !== mk(3'b110, 3))
            $display("FAIL swap_const: rref=%h rank=%0d pm=%h required %h/2/%h", rref, rank, pivot_mask, e, mk(3'b110, 3));
        else n_pass++;
        release_result("swap");

        m = '0; m[0] = mk(3'b110, 3); m[1] = mk(3'b111, 3);
        run("aug_incons", m, 2, 3, 1'b1);
        n_tot++;
        if (consistent !== 1'b0 || rank !== RW'(1) || pivot_mask !== mk(3'b100, 3))
            $display("FAIL aug_incons_const: cons=%b rank=%0d pm=%h required 0/1/%h", consistent, rank, pivot_mask, mk(3'b100, 3));
        else n_pass++;
        release_result("aug_incons");

        m = '0; m[0] = mk(3'b111, 3); m[1] = mk(3'b111, 3);
        run("aug_cons", m, 2, 3, 1'b1);
        n_tot++;
        if (consistent !== 1'b1 || rank !== RW'(1)) $display("FAIL aug_cons_const: cons=%b rank=%0d required 1/1", consistent, rank);
        else n_pass++;
        release_result("aug_cons");

        m = '0;
        run("zero4", m, 4, 4, 1'b0);
        release_result("zero4");

        for (int r = 0; r < MR; r++) m[r] = MC'($urandom);
        run("rows0", m, 0, MC, 1'b0);
        n_tot++;
        if (rank !== '0 || rref !== '0) $display("FAIL rows0_const: rank=%0d rref=%h required 0/0", rank, rref);
        else n_pass++;
        release_result("rows0");
    endtask

    task automatic test_random_hold();
        mat_t m;
        int   nr, nc;
        bit   aug, ok;
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < MR; r++)
                m[r] = (k % 2 == 1) ? MC'($urandom & $urandom & $urandom) : MC'($urandom);
            nr  = (k < 4) ? MR : $urandom_range(1, 31);
            nc  = (k < 4) ? MC : $urandom_range(1, 31);
            aug = 1'($urandom_range(0, 1));
            run("random", m, nr, nc, aug);
            ok = 1'b1;
            for (int h = 0; h < 10; h++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || rref !== exp_rref ||
                    rank !== RW'(exp_rank) || pivot_mask !== exp_pm) ok = 1'b0;
            end
            n_tot++;
            if (!ok) $display("FAIL hold_stable: k=%0d outputs moved or handshake wrong while out_ready low", k);
            else n_pass++;
            release_result("random");
        end
    endtask

    task automatic test_reset_mid();
        mat_t m;
        for (int r = 0; r < MR; r++) m[r] = MC'($urandom);
        send(m, MR, MC, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tot++;
        if (out_valid !== 1'b0 || rank !== '0 || in_ready !== 1'b1)
            $display("FAIL reset_mid: out_valid=%b rank=%0d in_ready=%b required 0/0/1", out_valid, rank, in_ready);
        else n_pass++;
        for (int r = 0; r < MR; r++) m[r] = MC'($urandom);
        run("after_reset", m, MR, MC, 1'b1);
        release_result("after_reset");
    endtask

    task automatic test_back_to_back();
        mat_t m;
        int   cyc;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < MR; r++) m[r] = MC'($urandom);
            send(m, 12, 10, 1'(k));
            wait_done(cyc);
            check_result("b2b", m, 12, 10, 1'(k));
            @(negedge clk);
            n_tot++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL b2b_turnaround: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
            else n_pass++;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aug_mode  = 1'b0;
        rows      = '0;
        cols      = '0;
        mat_in    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_latency_1x1();
        test_directed();
        test_random_hold();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/gf2_rref_engine.md
# gf2_rref_engine

Parametrised GF(2) Gauss-Jordan engine: accepts a runtime-sized bit matrix over a valid/ready handshake and reduces it to reduced row-echelon form. It also reports rank, pivot-column mask and, in augmented mode, system consistency, so downstream solvers need no extra pass. It sits between the puzzle-input parser and the minimum-weight solution search, replacing the start/ready-pulse reducer for new designs.

## Interface
- MAX_ROWS, 16, row capacity (≥1)
- MAX_COLS, 16, column capacity including any RHS column (≥1)
- MAX_ROWS_W, $clog2(MAX_ROWS+1) (1 if MAX_ROWS≤1), width of row counts
- MAX_COLS_W, $clog2(MAX_COLS+1) (1 if MAX_COLS≤1), width of column counts
- clk  in  1  sole clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  matrix offered
- in_ready  out  1  engine idle and able to capture
- rows  in  MAX_ROWS_W  active rows, sampled at capture
- cols  in  MAX_COLS_W  active columns incl. RHS, sampled at capture
- aug_mode  in  1  1: last active column is RHS, never pivoted
- mat_in  in  [MAX_COLS-1:0] x MAX_ROWS  row r = mat_in[r]; column j = bit MAX_COLS-1-j
- out_valid  out  1  result available, held until accepted
- out_ready  in  1  downstream accepts result
- rref  out  [MAX_COLS-1:0] x MAX_ROWS  reduced matrix, same bit ordering
- rank  out  MAX_ROWS_W  number of pivots found
- pivot_mask  out  MAX_COLS  bit of column j set if column j holds a pivot
- consistent  out  1  aug_mode: RHS column has no pivot; 1 when aug_mode=0

## Operation
- States: IDLE, SCAN, SWAP, ELIM, NEXT_COL, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch rows, cols, aug_mode; load mat_in with rows ≥ rows and columns ≥ cols zeroed; col=0, prow=0; go to SCAN. Go to DONE instead if rows=0 or coefficient columns (cols−aug_mode) = 0.
- SCAN: search rows prow..rows−1 for a 1 in column col. Serial search: one row per cycle. Hit at row p: go to SWAP if p≠prow, else ELIM. Miss: go to NEXT_COL.
- SWAP: exchange rows p and prow; go to ELIM.
- ELIM: every row r≠prow with bit col set gets row prow XORed into it, all in one cycle, above and below; set pivot_mask[col]; increment prow and rank; go to NEXT_COL.
- NEXT_COL: col+1. Go to DONE if col+1 = cols−aug_mode or prow = rows (early exit), else SCAN.
- DONE: out_valid=1, outputs stable. On out_ready, go to IDLE the next cycle. in_ready=0.
- consistent = !aug_mode || no row r ≥ rank has RHS bit set. Computed in DONE entry.
- rows > MAX_ROWS or cols > MAX_COLS: saturated to MAX at capture.

## Timing
- Reset values: in_ready=1 once out of reset; out_valid=0; rref all 0; rank=0; pivot_mask=0; consistent=1; state IDLE.
- Asserting rst_n low mid-operation aborts immediately. No result is produced.
- Capture to out_valid, serial scan: Σ over processed columns of (scanned rows + 1 SWAP if needed + 1 ELIM if hit + 1 NEXT_COL) + 1 cycle.
- 1×1 matrix [1], aug_mode=0: out_valid 4 cycles after the capture edge (SCAN, ELIM, NEXT_COL, DONE).
- Outputs change only on entry to DONE.
- out_valid with out_ready already high: accepted in the first DONE cycle. in_ready returns 1 the following cycle, giving 1-cycle minimum turnaround.

## Configuration
- GF2_RREF_ENGINE_FAST_SCAN_EN defined: SCAN resolves in exactly 1 cycle using a priority encoder over rows prow..rows−1 (lowest index wins).
- GF2_RREF_ENGINE_FAST_SCAN_EN undefined: serial one-row-per-cycle search.
- Results are bit-identical either way; only latency differs. The bench must not depend on exact latency except in the 1×1 check, which holds in both builds.

## Structure
- Package gf2_pkg: state_t enum, width helper functions, and shared row/column index typedefs reused by the downstream solver.
- Sub-module gf2_pivot_scan: given the column slice, prow, rows and a start pulse, returns hit/p. It is serial or parallel per the macro; the FSM is unchanged.

## Test plan
- 3×3 identity, aug_mode=0 → rref=identity, rank=3, pivot_mask=111 in columns 0–2, consistent=1.
- Rows {011,101,110} as 3×3, aug_mode=0 → rref {101,011,000}, rank=2, pivot_mask columns {0,1}, swap exercised.
- Augmented 2×3 rows {11|0, 11|1}, aug_mode=1 → rank=1, RHS unpivoted, consistent=0. Same with RHS {1,1} → consistent=1.
- All-zero 4×4 → rank=0, pivot_mask=0, rref=0. Also rows=0 → immediate DONE, rank=0.
- MAX_ROWS×MAX_COLS random matrices vs. software reference, with out_ready held low 10 cycles → outputs stable, in_ready=0 throughout.
- rst_n pulsed low during SCAN → out_valid=0, rank=0, in_ready=1 after release. Next matrix processes correctly.
